// File: rtl/spi_cmd_master.sv
// rtl/spi_cmd_master.sv - SPI master issuing one {rd, adr, wdata} command frame, MSB first
// Captures the slave reply during the data phase; sdi is 2-flop synchronised.
module spi_cmd_master #(
  parameter int CLK_DIV    = 4,
  parameter int ADR_WIDTH  = 3,
  parameter int DATA_WIDTH = 8,
  parameter int CS_GAP     = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  rd_i,
  input  logic [ADR_WIDTH-1:0]  adr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  sck_o,
  output logic                  sel_o,
  output logic                  sdo_o,
  input  logic                  sdi_i
);

  localparam int N       = 1 + ADR_WIDTH + DATA_WIDTH;
  localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int BW      = $clog2(N + 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    GAP
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [N-1:0]          shift_q, shift_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  sck_q, sck_d;
  logic                  sel_q, sel_d;
  logic                  sdo_q, sdo_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  sync1_q, sync2_q;
  logic [DATA_WIDTH-1:0] rx_next;
  logic                  half_end;

  assign half_end = (cnt_q == CW'(CLK_DIV - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      sck_q   <= 1'b0;
      sel_q   <= 1'b1;
      sdo_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      sck_q   <= sck_d;
      sel_q   <= sel_d;
      sdo_q   <= sdo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sync1_q <= sdi_i;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    sck_d   = sck_q;
    sel_d   = sel_q;
    sdo_d   = sdo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    // Only data-phase bits carry reply data; rd/adr-phase samples are discarded.
    rx_next = (bit_q > BW'(1 + ADR_WIDTH)) ? {rx_q[DATA_WIDTH-2:0], sync2_q} : rx_q;

    case (state_q)
      IDLE: begin
        sel_d = 1'b1;
        sck_d = 1'b0;
        if (start_i) begin
          shift_d = {rd_i, adr_i, wdata_i};
          rx_d    = '0;
          sel_d   = 1'b0;
          sdo_d   = rd_i;
          busy_d  = 1'b1;
          cnt_d   = '0;
          bit_d   = BW'(1);
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (half_end) begin
          cnt_d   = '0;
          sck_d   = 1'b1;
          state_d = HIGH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HIGH: begin
        if (half_end) begin
          cnt_d   = '0;
          sck_d   = 1'b0;
          state_d = LOW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LOW: begin
        if (half_end) begin
          cnt_d = '0;
          rx_d  = rx_next;
          if (bit_q < BW'(N)) begin
            shift_d = {shift_q[N-2:0], 1'b0};
            sdo_d   = shift_q[N-2];
            sck_d   = 1'b1;
            bit_d   = bit_q + 1'b1;
            state_d = HIGH;
          end else begin
            sel_d   = 1'b1;
            sdo_d   = 1'b0;
            rdata_d = rx_next;
            done_d  = 1'b1;
            state_d = GAP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == CW'(CS_GAP - 1)) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = 1'b1;
        sck_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign rdata_o = rdata_q;
  assign sck_o   = sck_q;
  assign sel_o   = sel_q;
  assign sdo_o   = sdo_q;

endmodule
